// File: rtl/ccc_cfg_pkg.sv
// Shared definitions for the MSS CCC dynamic-configuration sequencer:
// word width, field layout within the configuration word, and FSM state codes.
package ccc_cfg_pkg;

    localparam int CCC_CFG_W = 81;

    // Field layout, LSB first in shift order
    localparam int FINDIV_OFS   = 0;   localparam int FINDIV_W   = 7;
    localparam int FBDIV_OFS    = 7;   localparam int FBDIV_W    = 7;
    localparam int OADIV_OFS    = 14;  localparam int OADIV_W    = 5;
    localparam int OADIVHALF_OFS = 19;
    localparam int OAMUX_OFS    = 20;  localparam int OAMUX_W    = 3;
    localparam int BYPASSA_OFS  = 23;
    localparam int DLYGLA_OFS   = 24;  localparam int DLYGLA_W   = 5;
    localparam int OBDIV_OFS    = 29;  localparam int OBDIV_W    = 5;
    localparam int OBDIVHALF_OFS = 34;
    localparam int OBMUX_OFS    = 35;  localparam int OBMUX_W    = 3;
    localparam int BYPASSB_OFS  = 38;
    localparam int DLYGLB_OFS   = 39;  localparam int DLYGLB_W   = 5;
    localparam int OCDIV_OFS    = 44;  localparam int OCDIV_W    = 5;
    localparam int OCDIVHALF_OFS = 49;
    localparam int OCMUX_OFS    = 50;  localparam int OCMUX_W    = 3;
    localparam int BYPASSC_OFS  = 53;
    localparam int DLYGLC_OFS   = 54;  localparam int DLYGLC_W   = 5;
    localparam int FBDLY_OFS    = 59;  localparam int FBDLY_W    = 5;
    localparam int FBSEL_OFS    = 64;  localparam int FBSEL_W    = 2;
    localparam int XDLYSEL_OFS  = 66;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SHIFT     = 3'd1;
    localparam logic [2:0] UPDATE    = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] WAIT_LOCK = 3'd4;

endpackage

// File: rtl/ccc_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into FAB_CLK.
module ccc_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // next-state for the synchronizer chain
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // synchronizer flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/mss_ccc_dyncfg_ctrl.sv
// Shifts a CCC dynamic-configuration word out serially, strobes SUPDATE,
// then waits for the PLL to relock and reports DONE or ERR.
module mss_ccc_dyncfg_ctrl
    import ccc_cfg_pkg::*;
#(
    parameter int CFG_W        = CCC_CFG_W,
    parameter int SCLK_DIV     = 2,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             CFG_REQ,
    input  logic [CFG_W-1:0] CFG_WORD,
    output logic             CFG_ACK,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             LOCKED,
    input  logic             PLL_LOCK,
    output logic             SDIN,
    output logic             SCLK,
    output logic             SSHIFT,
    output logic             SUPDATE,
    output logic             MODE
);

    localparam int BIT_W    = $clog2(CFG_W + 1);
    localparam int DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int WAIT_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(CFG_W);
    localparam logic [WAIT_W-1:0] SETTLE_LAST  = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);

    logic [2:0]        state_q,   state_d;
    logic [CFG_W-1:0]  sreg_q,    sreg_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [WAIT_W-1:0] wait_q,    wait_d;
    logic              sclk_q,    sclk_d;
    logic              sdin_q,    sdin_d;
    logic              sshift_q,  sshift_d;
    logic              supdate_q, supdate_d;
    logic              ack_q,     ack_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;
    logic              locked_q,  locked_d;
    logic              mode_q,    mode_d;

    logic              lock_s;
    logic              half_end_s;
    logic [CFG_W-1:0]  sreg_next_s;

    ccc_lock_sync u_lock_sync (
        .clk      (FAB_CLK),
        .rst_n    (M2F_RESET_N),
        .async_in (PLL_LOCK),
        .sync_out (lock_s)
    );

    assign half_end_s  = (div_q == DIV_LAST);
    assign sreg_next_s = {1'b0, sreg_q[CFG_W-1:1]};

    // sequencer next-state: SCLK generation, shifting, update strobe, lock wait
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        div_d     = div_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        sclk_d    = sclk_q;
        sdin_d    = sdin_q;
        sshift_d  = sshift_q;
        supdate_d = supdate_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mode_d    = mode_q;
        case (state_q)
            IDLE: begin
                if (CFG_REQ) begin
                    state_d  = SHIFT;
                    sreg_d   = CFG_WORD;
                    sdin_d   = CFG_WORD[0];
                    sshift_d = 1'b1;
                    ack_d    = 1'b1;
                    busy_d   = 1'b1;
                    mode_d   = 1'b1;
                    div_d    = '0;
                    bit_d    = '0;
                    sclk_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (half_end_s) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        bit_d = bit_q + BIT_W'(1);
                    end else begin
                        // falling edge: advance the register; data changes only while SCLK is low
                        sreg_d = sreg_next_s;
                        if (bit_q == BIT_LAST) begin
                            state_d   = UPDATE;
                            sshift_d  = 1'b0;
                            supdate_d = 1'b1;
                            sdin_d    = 1'b0;
                        end else begin
                            sdin_d = sreg_next_s[0];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            UPDATE: begin
                if (half_end_s) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        supdate_d = 1'b0;
                        state_d   = SETTLE;
                        wait_d    = '0;
                    end else begin
                        supdate_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = WAIT_LOCK;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // lock is checked first so it wins on the timeout cycle
                if (lock_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (wait_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                sclk_d    = 1'b0;
                sdin_d    = 1'b0;
                sshift_d  = 1'b0;
                supdate_d = 1'b0;
            end
        endcase
        locked_d = lock_s & ~busy_d;
    end

    // sequencer state and registered outputs
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            wait_q    <= '0;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            sshift_q  <= 1'b0;
            supdate_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            sshift_q  <= sshift_d;
            supdate_q <= supdate_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            mode_q    <= mode_d;
        end
    end

    assign CFG_ACK = ack_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign LOCKED  = locked_q;
    assign SDIN    = sdin_q;
    assign SCLK    = sclk_q;
    assign SSHIFT  = sshift_q;
    assign SUPDATE = supdate_q;
    assign MODE    = mode_q;

endmodule
